// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment display scheduler.
// Segment patterns are active-low, bit 0 = segment a, bit 6 = segment g.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] DIG_OFF   = 4'b1111;

    function automatic state_t own_state(input logic owner);
        return owner ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg_display_sched.sv
// Two-requester arbiter for a 4-digit multiplexed seven-segment display: the owner's
// digits are scanned one per tick and ownership only moves at frame boundaries.
module seg_display_sched
    import seg_pkg::*;
#(
    parameter int TICK_DIV    = 50000,
    parameter int HOLD_FRAMES = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  REQ,
    input  logic [15:0] DATA0,
    input  logic [15:0] DATA1,
    output logic [1:0]  GNT,
    output logic [6:0]  SevOut,
    output logic [3:0]  Dig
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int FW = $clog2(HOLD_FRAMES + 1);
    localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FRAME_MAX = FW'(HOLD_FRAMES);

    state_t          r_state;
    logic [TW-1:0]   r_tick_cnt;
    logic [1:0]      r_idx;
    logic [FW-1:0]   r_frame_cnt;
    logic            r_rr;

    state_t          w_nxt_state;
    logic [1:0]      w_nxt_idx;
    logic [FW-1:0]   w_nxt_frame;
    logic            w_nxt_rr;
    logic            w_tick;
    logic            w_own;
    logic [FW-1:0]   w_frames_done;
    logic [15:0]     w_data;
    logic [3:0]      w_nibble;
    logic [6:0]      w_seg;

    assign w_tick = (r_tick_cnt == TICK_MAX);
    assign w_own  = (r_state == ST_OWN1);
    // Frames completed including the one ending at this boundary.
    assign w_frames_done = (r_frame_cnt == FRAME_MAX) ? FRAME_MAX : r_frame_cnt + 1'b1;

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_frame = r_frame_cnt;
        w_nxt_rr    = r_rr;
        if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (REQ != 2'b00) begin
                        w_nxt_state = own_state((REQ == 2'b11) ? r_rr : REQ[1]);
                        w_nxt_rr    = ~((REQ == 2'b11) ? r_rr : REQ[1]);
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    if (r_idx != 2'd3) begin
                        w_nxt_idx = r_idx + 2'd1;
                    end else if (!REQ[w_own] || (REQ[~w_own] && w_frames_done >= FRAME_MAX)) begin
                        w_nxt_idx   = 2'd0;
                        w_nxt_frame = '0;
                        if (REQ[~w_own]) begin
                            w_nxt_state = own_state(~w_own);
                            w_nxt_rr    = w_own;
                        end else begin
                            w_nxt_state = ST_IDLE;
                        end
                    end else begin
                        w_nxt_idx   = 2'd0;
                        w_nxt_frame = w_frames_done;
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_idx   = 2'd0;
                    w_nxt_frame = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state, so the decode looks ahead one edge.
    assign w_data   = (w_nxt_state == ST_OWN1) ? DATA1 : DATA0;
    assign w_nibble = w_data[{w_nxt_idx, 2'b00} +: 4];

    hex_seg_decode u_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_tick_cnt  <= '0;
            r_idx       <= 2'd0;
            r_frame_cnt <= '0;
            r_rr        <= 1'b0;
            GNT         <= 2'b00;
            Dig         <= DIG_OFF;
            SevOut      <= SEG_BLANK;
        end else begin
            r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_state     <= w_nxt_state;
            r_idx       <= w_nxt_idx;
            r_frame_cnt <= w_nxt_frame;
            r_rr        <= w_nxt_rr;
            case (w_nxt_state)
                ST_OWN0: GNT <= 2'b01;
                ST_OWN1: GNT <= 2'b10;
                default: GNT <= 2'b00;
            endcase
            if (w_nxt_state == ST_IDLE) begin
                Dig    <= DIG_OFF;
                SevOut <= SEG_BLANK;
            end else begin
                Dig    <= ~(4'b0001 << w_nxt_idx);
                SevOut <= w_seg;
            end
        end
    end

endmodule
